// File: rtl/mod_n_counter_if.sv
// Command and status bundle for mod_n_counter: the controller drives the
// commands (master), the counter drives the count and flags (slave).
interface mod_n_counter_if #(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 2
);
  logic                      CLR;
  logic                      LOAD;
  logic [DIGITS*WIDTH-1:0]   LD_VAL;
  logic                      INC;
  logic                      DEC;
  logic [DIGITS*WIDTH-1:0]   Q;
  logic                      CARRY;
  logic                      BORROW;
  logic                      LD_ERR;

  modport master (
    output CLR, LOAD, LD_VAL, INC, DEC,
    input  Q, CARRY, BORROW, LD_ERR
  );

  modport slave (
    input  CLR, LOAD, LD_VAL, INC, DEC,
    output Q, CARRY, BORROW, LD_ERR
  );
endinterface

// File: rtl/mod_n_counter.sv
// Cascadable modulo-MOD up/down counter of DIGITS digits with clear, load and
// registered wrap/load-error flags. Define MODN_SAT_EN to saturate instead of wrap.
module mod_n_counter #(
  parameter int MOD    = 10,
  parameter int WIDTH  = 4,
  parameter int DIGITS = 2
) (
  input  logic           CLK,
  input  logic           nReset,
  mod_n_counter_if.slave bus
);

  localparam int               TW   = DIGITS * WIDTH;
  localparam logic [WIDTH-1:0] DMAX = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MODX = (WIDTH + 1)'(MOD);
`ifdef MODN_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  logic [TW-1:0]     q_q, q_d;
  logic              carry_q, carry_d;
  logic              borrow_q, borrow_d;
  logic              ld_err_q, ld_err_d;
  logic [DIGITS-1:0] inc_en, dec_en;
  logic              all_max, all_zero;
  logic              run_up, run_dn;

  function automatic logic [WIDTH-1:0] digit_up(input logic [WIDTH-1:0] d);
    return (d == DMAX) ? '0 : d + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] digit_down(input logic [WIDTH-1:0] d);
    return (d == '0) ? DMAX : d - WIDTH'(1);
  endfunction

  function automatic logic field_bad(input logic [WIDTH-1:0] f);
    return {1'b0, f} >= MODX;
  endfunction

  // Ripple enables: digit k steps when every lower digit sits at its wrap point.
  always_comb begin
    run_up = 1'b1;
    run_dn = 1'b1;
    inc_en = '0;
    dec_en = '0;
    for (int k = 0; k < DIGITS; k++) begin
      inc_en[k] = run_up;
      dec_en[k] = run_dn;
      run_up    = run_up & (q_q[k*WIDTH +: WIDTH] == DMAX);
      run_dn    = run_dn & (q_q[k*WIDTH +: WIDTH] == '0);
    end
    all_max  = run_up;
    all_zero = run_dn;
  end

  always_comb begin
    q_d      = q_q;
    carry_d  = 1'b0;
    borrow_d = 1'b0;
    ld_err_d = 1'b0;
    if (bus.CLR) begin
      q_d = '0;
    end else if (bus.LOAD) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (field_bad(bus.LD_VAL[k*WIDTH +: WIDTH])) begin
          q_d[k*WIDTH +: WIDTH] = '0;
          ld_err_d              = 1'b1;
        end else begin
          q_d[k*WIDTH +: WIDTH] = bus.LD_VAL[k*WIDTH +: WIDTH];
        end
      end
    end else if (bus.INC && !bus.DEC) begin
      carry_d = all_max;
      if (!(SAT_EN && all_max)) begin
        for (int k = 0; k < DIGITS; k++)
          if (inc_en[k]) q_d[k*WIDTH +: WIDTH] = digit_up(q_q[k*WIDTH +: WIDTH]);
      end
    end else if (bus.DEC && !bus.INC) begin
      borrow_d = all_zero;
      if (!(SAT_EN && all_zero)) begin
        for (int k = 0; k < DIGITS; k++)
          if (dec_en[k]) q_d[k*WIDTH +: WIDTH] = digit_down(q_q[k*WIDTH +: WIDTH]);
      end
    end
  end

  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      q_q      <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      ld_err_q <= 1'b0;
    end else begin
      q_q      <= q_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      ld_err_q <= ld_err_d;
    end
  end

  assign bus.Q      = q_q;
  assign bus.CARRY  = carry_q;
  assign bus.BORROW = borrow_q;
  assign bus.LD_ERR = ld_err_q;

endmodule

// File: tb/tb_mod_n_counter.sv
// Scoreboard bench for mod_n_counter: a 2-digit BCD instance and a legacy
// mod-4 single-digit instance, both checked against an integer-value model.
module tb_mod_n_counter;

  localparam int MODA = 10, WA = 4, DA = 2;
  localparam int MODB = 4,  WB = 2, DB = 1;
`ifdef MODN_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] q;
    logic        c;
    logic        b;
    logic        e;
  } exp_t;

  logic CLK = 1'b0;
  logic nReset = 1'b0;
  always #5 CLK = ~CLK;

  mod_n_counter_if #(.WIDTH(WA), .DIGITS(DA)) bus_a ();
  mod_n_counter_if #(.WIDTH(WB), .DIGITS(DB)) bus_b ();

  mod_n_counter #(.MOD(MODA), .WIDTH(WA), .DIGITS(DA)) u_a (
    .CLK(CLK), .nReset(nReset), .bus(bus_a)
  );
  mod_n_counter #(.MOD(MODB), .WIDTH(WB), .DIGITS(DB)) u_b (
    .CLK(CLK), .nReset(nReset), .bus(bus_b)
  );

  exp_t qa[$];
  exp_t qb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   val_a = 0;
  int   val_b = 0;

  // Count held as a plain integer 0..MOD**DIGITS-1; digits derived on output.
  function automatic logic [31:0] encode(input int v, input int mod, input int width,
                                         input int digits);
    logic [31:0] r;
    int          t;
    r = '0;
    t = v;
    for (int k = 0; k < digits; k++) begin
      r = r | (32'(t % mod) << (k * width));
      t = t / mod;
    end
    return r;
  endfunction

  task automatic model(input int mod, input int width, input int digits,
                       input bit clr, input bit load, input logic [31:0] ldv,
                       input bit inc, input bit dec, inout int val, output exp_t e);
    int total, mult, f;
    total = 1;
    for (int k = 0; k < digits; k++) total = total * mod;
    e = '0;
    if (clr) begin
      val = 0;
    end else if (load) begin
      val  = 0;
      mult = 1;
      for (int k = 0; k < digits; k++) begin
        f = int'((ldv >> (k * width)) & ((32'd1 << width) - 32'd1));
        if (f >= mod) begin
          e.e = 1'b1;
          f   = 0;
        end
        val  = val + f * mult;
        mult = mult * mod;
      end
    end else if (inc && !dec) begin
      if (val == total - 1) begin
        e.c = 1'b1;
        if (!SAT) val = 0;
      end else begin
        val = val + 1;
      end
    end else if (dec && !inc) begin
      if (val == 0) begin
        e.b = 1'b1;
        if (!SAT) val = total - 1;
      end else begin
        val = val - 1;
      end
    end
    e.q = encode(val, mod, width, digits);
  endtask

  task automatic check(input string name, input exp_t act, input exp_t req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s t=%0t: got Q=%h C=%b B=%b E=%b, want Q=%h C=%b B=%b E=%b",
               name, $time, act.q, act.c, act.b, act.e, req.q, req.c, req.b, req.e);
    end
  endtask

  function automatic exp_t sample_a();
    exp_t a;
    a.q = 32'(bus_a.Q);
    a.c = bus_a.CARRY;
    a.b = bus_a.BORROW;
    a.e = bus_a.LD_ERR;
    return a;
  endfunction

  function automatic exp_t sample_b();
    exp_t a;
    a.q = 32'(bus_b.Q);
    a.c = bus_b.CARRY;
    a.b = bus_b.BORROW;
    a.e = bus_b.LD_ERR;
    return a;
  endfunction

  task automatic idle_a();
    bus_a.CLR = 0; bus_a.LOAD = 0; bus_a.LD_VAL = '0; bus_a.INC = 0; bus_a.DEC = 0;
  endtask

  task automatic idle_b();
    bus_b.CLR = 0; bus_b.LOAD = 0; bus_b.LD_VAL = '0; bus_b.INC = 0; bus_b.DEC = 0;
  endtask

  // sel=0 drives the BCD instance, sel=1 the mod-4 instance; the other idles.
  task automatic step(input bit sel, input bit clr, input bit load,
                      input logic [31:0] ldv, input bit inc, input bit dec);
    exp_t e;
    @(negedge CLK);
    if (!sel) begin
      idle_b();
      bus_a.CLR = clr; bus_a.LOAD = load; bus_a.LD_VAL = ldv[WA*DA-1:0];
      bus_a.INC = inc; bus_a.DEC = dec;
      model(MODA, WA, DA, clr, load, ldv, inc, dec, val_a, e);
      qa.push_back(e);
    end else begin
      idle_a();
      bus_b.CLR = clr; bus_b.LOAD = load; bus_b.LD_VAL = ldv[WB*DB-1:0];
      bus_b.INC = inc; bus_b.DEC = dec;
      model(MODB, WB, DB, clr, load, ldv, inc, dec, val_b, e);
      qb.push_back(e);
    end
  endtask

  // Reset pulse between edges: outputs must clear without any clock edge.
  task automatic async_reset();
    exp_t z;
    z = '0;
    @(negedge CLK);
    idle_a();
    idle_b();
    #1 nReset = 1'b0;
    #1;
    check("async_rst_a", sample_a(), z);
    check("async_rst_b", sample_b(), z);
    #1 nReset = 1'b1;
    val_a = 0;
    val_b = 0;
    qa.push_back(z);
    qb.push_back(z);
  endtask

  initial begin : mon_a
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (qa.size() != 0) begin
        e = qa.pop_front();
        check("cnt_a", sample_a(), e);
      end
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (qb.size() != 0) begin
        e = qb.pop_front();
        check("cnt_b", sample_b(), e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    exp_t        z;
    int          r;
    bit          sel, clr, load, inc, dec;
    logic [31:0] ldv;
    logic [31:0] edges [4];
    edges[0] = 32'h99; edges[1] = 32'h00; edges[2] = 32'h98; edges[3] = 32'h01;
    z = '0;
    idle_a();
    idle_b();
    #2;
    check("reset_a", sample_a(), z);
    check("reset_b", sample_b(), z);
    @(negedge CLK);
    nReset = 1'b1;

    // Reset mid-count, then first increment
    step(0, 0, 1, 32'h57, 0, 0);
    async_reset();
    step(0, 0, 0, 0, 1, 0);
    // Full-count wrap on increment
    step(0, 0, 1, 32'h98, 0, 0);
    repeat (3) step(0, 0, 0, 0, 1, 0);
    // Wrap on decrement
    step(0, 1, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 1);
    // Out-of-range load fields
    step(0, 0, 1, 32'h3A, 0, 0);
    step(0, 0, 1, 32'hF2, 0, 0);
    step(0, 0, 1, 32'h27, 0, 0);
    // Command priority
    step(0, 0, 1, 32'h45, 0, 0);
    step(0, 1, 1, 32'h12, 1, 0);
    step(0, 0, 1, 32'h45, 0, 0);
    step(0, 0, 1, 32'h12, 1, 0);
    step(0, 0, 1, 32'h45, 0, 0);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 1, 1);
    // Legacy mod-4 sequence from reset
    repeat (5) step(1, 0, 0, 0, 1, 0);
    repeat (3) step(1, 0, 0, 0, 0, 1);

    // Randomised commands, loads biased toward wrap points
    for (int i = 0; i < 500; i++) begin
      sel  = ($urandom_range(0, 3) == 0);
      r    = int'($urandom_range(0, 99));
      clr  = (r < 3);
      load = (r >= 3 && r < 15);
      inc  = $urandom_range(0, 99) < 55;
      dec  = $urandom_range(0, 99) < 40;
      if ($urandom_range(0, 2) == 0) ldv = edges[$urandom_range(0, 3)];
      else                           ldv = $urandom;
      step(sel, clr, load, ldv, inc, dec);
    end

    @(negedge CLK);
    idle_a();
    idle_b();
    repeat (3) @(negedge CLK);
    vectors++;
    if (qa.size() != 0 || qb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d/%0d pending entries, want 0/0", qa.size(), qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
